// File: rtl/stream_palindrome_detector_pkg.sv
// Shared types, symbol-width legality rules and the pair-reduction helper.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package pal_pkg;

  typedef enum logic {FILL, FULL} pal_state_e;

  // Upper bound on symbol pairs a window may hold (NSYM/2).
  localparam int PAL_MAX_PAIRS = 128;

  // Symbols are bits, nibbles or bytes.
  function automatic bit sym_w_legal(input int sym_w);
    return (sym_w == 1) || (sym_w == 4) || (sym_w == 8);
  endfunction

  // The instantiating module generates one equality bit per mirrored
  // symbol pair and pads the unused positions with 1.
  function automatic logic is_palindrome(input logic [PAL_MAX_PAIRS-1:0] pair_eq);
    return &pair_eq;
  endfunction

endpackage

// File: rtl/stream_palindrome_detector_if.sv
// Symbol stream in, palindrome status out; the hit_count signal exists only with PAL_HIT_CNT_EN.
// Latency: none (wiring only).
// Backpressure: none; the stream is strobe-only and every strobe is accepted.
interface stream_palindrome_detector_if #(
  parameter int SYM_W = 1,
  parameter int FC_W  = 6
`ifdef PAL_HIT_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic             clear;
  logic             din_valid;
  logic [SYM_W-1:0] din;
  logic             dout;
  logic             dout_valid;
  logic             full;
  logic [FC_W-1:0]  fill_count;
`ifdef PAL_HIT_CNT_EN
  logic [CNT_W-1:0] hit_count;
`endif

  modport master (
    output clear, din_valid, din,
    input  dout, dout_valid, full, fill_count
`ifdef PAL_HIT_CNT_EN
    , input hit_count
`endif
  );

  modport slave (
    input  clear, din_valid, din,
    output dout, dout_valid, full, fill_count
`ifdef PAL_HIT_CNT_EN
    , output hit_count
`endif
  );
endinterface

// File: rtl/stream_palindrome_detector_palindrome_check.sv
// Combinational symbol-wise palindrome test of an NSYM x SYM_W window; the middle symbol is ignored when NSYM is odd.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module palindrome_check
  import pal_pkg::*;
#(
  parameter int NSYM  = 32,
  parameter int SYM_W = 1
) (
  input  logic [NSYM*SYM_W-1:0] win,
  output logic                  match
);
  localparam int NPAIR = NSYM / 2;

  logic [PAL_MAX_PAIRS-1:0] pair_eq;

  // Symbol i is mirrored against symbol NSYM-1-i; unused slots read as equal.
  for (genvar i = 0; i < PAL_MAX_PAIRS; i++) begin : g_pair
    if (i < NPAIR) begin : g_cmp
      assign pair_eq[i] = (win[i*SYM_W +: SYM_W] == win[(NSYM-1-i)*SYM_W +: SYM_W]);
    end else begin : g_pad
      assign pair_eq[i] = 1'b1;
    end
  end

  assign match = is_palindrome(pair_eq);
endmodule

// File: rtl/stream_palindrome_detector.sv
// Sliding-window palindrome monitor over a serial symbol stream; optional saturating hit counter with PAL_HIT_CNT_EN.
// Latency: 1 cycle from an accepting edge to dout/dout_valid; dout holds while idle.
// Backpressure: none; a symbol is taken on every din_valid edge at full rate, and clear drops a coincident symbol.
module stream_palindrome_detector
  import pal_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SYM_W = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  stream_palindrome_detector_if.slave  bus
);
  localparam int NSYM = WIDTH / SYM_W;
  localparam int FC_W = $clog2(NSYM + 1);

  if (!sym_w_legal(SYM_W)) begin : g_bad_sym_w
    $error("stream_palindrome_detector: SYM_W must be 1, 4 or 8");
  end
  if ((WIDTH % SYM_W) != 0) begin : g_bad_width
    $error("stream_palindrome_detector: WIDTH must be a multiple of SYM_W");
  end
  if (NSYM < 2) begin : g_bad_nsym
    $error("stream_palindrome_detector: window must hold at least 2 symbols");
  end
  if ((NSYM / 2) > PAL_MAX_PAIRS) begin : g_too_wide
    $error("stream_palindrome_detector: window has too many symbols");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("stream_palindrome_detector: CNT_W must be at least 1");
  end

  pal_state_e       state, state_nxt;
  logic [FC_W-1:0]  fill_count, fill_nxt;
  logic [WIDTH-1:0] window;
  logic             dout_valid;
  logic             win_pal;
  logic             dout_int;
  logic             accept;

  // clear has priority: a symbol presented alongside it is discarded.
  assign accept = bus.din_valid & ~bus.clear;

  palindrome_check #(
    .NSYM  (NSYM),
    .SYM_W (SYM_W)
  ) u_check (
    .win   (window),
    .match (win_pal)
  );

  // Fill/full state and fill counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      fill_count <= '0;
    end else begin
      state      <= state_nxt;
      fill_count <= fill_nxt;
    end
  end

  // Count accepts until the window is full; only clear returns to FILL.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_count;
    case (state)
      FILL: begin
        if (accept) begin
          fill_nxt = fill_count + 1'b1;
          if (fill_count == FC_W'(NSYM - 1)) begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        fill_nxt = FC_W'(NSYM);
      end
      default: begin
        state_nxt = FILL;
        fill_nxt  = '0;
      end
    endcase
    if (bus.clear) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end
  end

  // Newest symbol enters at the LSB; the oldest falls off the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window <= '0;
    end else if (bus.clear) begin
      window <= '0;
    end else if (accept) begin
      window <= {window[WIDTH-SYM_W-1:0], bus.din};
    end
  end

  // One-cycle strobe marking that dout reflects a freshly accepted symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= accept;
    end
  end

  assign dout_int       = (state == FULL) & win_pal;
  assign bus.dout       = dout_int;
  assign bus.dout_valid = dout_valid;
  assign bus.full       = (state == FULL);
  assign bus.fill_count = fill_count;

`ifdef PAL_HIT_CNT_EN
  logic [CNT_W-1:0] hit_count;

  // Count reported palindromes, sticking at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
    end else if (dout_valid && dout_int && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + 1'b1;
    end
  end

  assign bus.hit_count = hit_count;
`endif
endmodule

// File: tb/tb_stream_palindrome_detector.sv
// Bench for two configurations (8x1-bit and 4x4-bit windows) against a symbol-history model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_stream_palindrome_detector;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef PAL_HIT_CNT_EN
  stream_palindrome_detector_if #(.SYM_W(1), .FC_W(4), .CNT_W(2))  if8 ();
  stream_palindrome_detector_if #(.SYM_W(4), .FC_W(3), .CNT_W(16)) if16 ();
`else
  stream_palindrome_detector_if #(.SYM_W(1), .FC_W(4)) if8 ();
  stream_palindrome_detector_if #(.SYM_W(4), .FC_W(3)) if16 ();
`endif

  stream_palindrome_detector #(.WIDTH(8), .SYM_W(1), .CNT_W(2)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  stream_palindrome_detector #(.WIDTH(16), .SYM_W(4), .CNT_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: history of the last NSYM accepted symbols (oldest first).
  int m8_q[$];
  int m16_q[$];
  int m8_fill, m16_fill;
  bit m8_dv, m16_dv;
  int m8_hits;

  function automatic bit pal(input int q[$]);
    int n;
    n = q.size();
    for (int i = 0; i < n / 2; i++) begin
      if (q[i] != q[n-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit exp_dout8();
    return (m8_fill == 8) && pal(m8_q);
  endfunction

  function automatic bit exp_dout16();
    return (m16_fill == 4) && pal(m16_q);
  endfunction

  function automatic logic [6:0] exp8();
    return {exp_dout8(), m8_dv, (m8_fill == 8), 4'(m8_fill)};
  endfunction

  function automatic logic [5:0] exp16();
    return {exp_dout16(), m16_dv, (m16_fill == 4), 3'(m16_fill)};
  endfunction

  function automatic logic [6:0] act8();
    return {if8.dout, if8.dout_valid, if8.full, if8.fill_count};
  endfunction

  function automatic logic [5:0] act16();
    return {if16.dout, if16.dout_valid, if16.full, if16.fill_count};
  endfunction

  task automatic model_reset();
    m8_q.delete();
    m16_q.delete();
    m8_fill  = 0;
    m16_fill = 0;
    m8_dv    = 1'b0;
    m16_dv   = 1'b0;
    m8_hits  = 0;
  endtask

  // Present one cycle of stimulus to both DUTs and advance the model.
  task automatic step(input bit v8, input bit d8, input bit c8,
                      input bit v16, input logic [3:0] d16, input bit c16);
    bit hit;
    if8.din_valid  = v8;
    if8.din        = d8;
    if8.clear      = c8;
    if16.din_valid = v16;
    if16.din       = d16;
    if16.clear     = c16;
    @(posedge clk);
    hit = m8_dv && exp_dout8();
    if (hit && m8_hits < 3) m8_hits++;
    if (c8) begin
      m8_q.delete(); m8_fill = 0; m8_dv = 1'b0;
    end else if (v8) begin
      m8_q.push_back(int'(d8));
      if (m8_q.size() > 8) void'(m8_q.pop_front());
      if (m8_fill < 8) m8_fill++;
      m8_dv = 1'b1;
    end else begin
      m8_dv = 1'b0;
    end
    if (c16) begin
      m16_q.delete(); m16_fill = 0; m16_dv = 1'b0;
    end else if (v16) begin
      m16_q.push_back(int'(d16));
      if (m16_q.size() > 4) void'(m16_q.pop_front());
      if (m16_fill < 4) m16_fill++;
      m16_dv = 1'b1;
    end else begin
      m16_dv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if8.din_valid = 1'b0; if8.din = '0; if8.clear = 1'b0;
    if16.din_valid = 1'b0; if16.din = '0; if16.clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (act8() !== 7'd0) begin
      mismatched++;
      $display("FAIL reset8: got %b want %b", act8(), 7'd0);
    end
    compared++;
    if (act16() !== 6'd0) begin
      mismatched++;
      $display("FAIL reset16: got %b want %b", act16(), 6'd0);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_bit_stream();
    logic [7:0] bits;
    bits = 8'b1001_1001;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i], 1'b0, 1'b0, 4'h0, 1'b0);
      compared++;
      if (act8() !== exp8()) begin
        mismatched++;
        $display("FAIL bits_accept%0d: got %b want %b", i + 1, act8(), exp8());
      end
    end
    compared++;
    if (act8() !== 7'b111_1000) begin
      mismatched++;
      $display("FAIL bits_full_pal: got %b want %b", act8(), 7'b111_1000);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    compared++;
    if (act8() !== 7'b011_1000) begin
      mismatched++;
      $display("FAIL bits_slide0: got %b want %b", act8(), 7'b011_1000);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      compared++;
      if (act8() !== 7'b001_1000 || act8() !== exp8()) begin
        mismatched++;
        $display("FAIL bits_idle%0d: got %b want %b", i, act8(), 7'b001_1000);
      end
    end
  endtask

  task automatic test_nibbles();
    logic [15:0] nib;
    nib = 16'hABBA;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, nib[15-4*i -: 4], 1'b0);
      compared++;
      if (act16() !== exp16()) begin
        mismatched++;
        $display("FAIL nib_accept%0d: got %b want %b", i + 1, act16(), exp16());
      end
    end
    compared++;
    if (act16() !== 6'b111_100) begin
      mismatched++;
      $display("FAIL nib_abba: got %b want %b", act16(), 6'b111_100);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0);
    compared++;
    if (act16() !== 6'b011_100) begin
      mismatched++;
      $display("FAIL nib_bbac: got %b want %b", act16(), 6'b011_100);
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    compared++;
    if (act8() !== 7'd0 || act8() !== exp8()) begin
      mismatched++;
      $display("FAIL clear_drop: got %b want %b", act8(), 7'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      compared++;
      if (act8() !== exp8() || if8.dout !== (i == 7)) begin
        mismatched++;
        $display("FAIL clear_zeros%0d: got %b want %b", i + 1, act8(), exp8());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    end
    if8.din_valid = 1'b1; if8.din = 1'b1;
    if16.din_valid = 1'b1; if16.din = 4'h3;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    compared++;
    if (act8() !== 7'd0) begin
      mismatched++;
      $display("FAIL async_reset8: got %b want %b", act8(), 7'd0);
    end
    compared++;
    if (act16() !== 6'd0) begin
      mismatched++;
      $display("FAIL async_reset16: got %b want %b", act16(), 6'd0);
    end
    if8.din_valid = 1'b0;
    if16.din_valid = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0);
    compared++;
    if (act8() !== 7'b010_0001 || act16() !== 6'b010_001) begin
      mismatched++;
      $display("FAIL restart: got %b/%b want %b/%b", act8(), act16(), 7'b010_0001, 6'b010_001);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
      compared++;
      if (act8() !== exp8() || act16() !== exp16() || !if8.dout_valid || !if16.dout_valid) begin
        mismatched++;
        $display("FAIL b2b%0d: got %b/%b want %b/%b", i, act8(), act16(), exp8(), exp16());
      end
    end
  endtask

  task automatic test_random();
    bit v8, d8, c8, v16, c16;
    logic [3:0] d16;
    for (int i = 0; i < 600; i++) begin
      v8  = ($urandom_range(0, 3) != 0);
      d8  = 1'($urandom_range(0, 1));
      c8  = ($urandom_range(0, 40) == 0);
      v16 = ($urandom_range(0, 3) != 0);
      d16 = ($urandom_range(0, 1) != 0) ? 4'hA : 4'h5;
      c16 = ($urandom_range(0, 40) == 0);
      step(v8, d8, c8, v16, d16, c16);
      compared++;
      if (act8() !== exp8() || act16() !== exp16()) begin
        mismatched++;
        $display("FAIL random%0d: got %b/%b want %b/%b", i, act8(), act16(), exp8(), exp16());
      end
`ifdef PAL_HIT_CNT_EN
      compared++;
      if (int'(if8.hit_count) !== m8_hits) begin
        mismatched++;
        $display("FAIL random_hits%0d: got %0d want %0d", i, if8.hit_count, m8_hits);
      end
`endif
    end
  endtask

`ifdef PAL_HIT_CNT_EN
  task automatic test_hit_count();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    end
    compared++;
    if (if8.hit_count !== 2'd3 || int'(if8.hit_count) !== m8_hits) begin
      mismatched++;
      $display("FAIL hit_saturate: got %0d want %0d", if8.hit_count, 3);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    compared++;
    if (if8.hit_count !== 2'd3 || if8.full !== 1'b0) begin
      mismatched++;
      $display("FAIL hit_after_clear: got %0d full %b want 3 full 0", if8.hit_count, if8.full);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bit_stream();
    test_nibbles();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef PAL_HIT_CNT_EN
    test_hit_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_palindrome_detector.md
Name: stream_palindrome_detector

Overview:
Sequential, parametrised successor to the combinational 32-bit palindrome detector. Symbols arrive serially (bit, nibble or byte granularity) into a sliding window of WIDTH bits. The block flags when the last NSYM accepted symbols form a palindrome. It sits on a serial data path as a pattern monitor and feeds status/interrupt logic.

Parameters:
- WIDTH, 32, window width in bits; WIDTH % SYM_W == 0 is required.
- SYM_W, 1, symbol width in bits (1, 4 or 8); palindrome comparison is symbol-wise.
- NSYM, WIDTH/SYM_W (derived localparam), symbols per window; NSYM >= 2 is required. Violation of either rule is an elaboration error ($error).
- CNT_W, 16, hit counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous flush of window and fill state
- din_valid  in  1  symbol strobe; din is accepted on each rising edge where din_valid=1
- din  in  SYM_W  input symbol
- dout  out  1  window full AND window is a palindrome
- dout_valid  out  1  one-cycle pulse: dout reflects a newly accepted symbol
- full  out  1  NSYM symbols accepted since reset/clear
- fill_count  out  $clog2(NSYM+1)  symbols held, saturates at NSYM
- hit_count  out  CNT_W  present only with PAL_HIT_CNT_EN

Behaviour:
- Reset (async, active-high): window=0, fill_count=0, state=FILL, dout=0, dout_valid=0, full=0, hit_count=0.
- Window shift on accept: window <= {window[WIDTH-SYM_W-1:0], din}. The newest symbol is at the LSB and the oldest at the MSB.
- Palindrome definition: symbol i == symbol NSYM-1-i for all i < NSYM/2. When NSYM is odd, the middle symbol is ignored.
- FSM states: FILL, FULL.
  - FILL: each accept increments fill_count.
  - FILL -> FULL on the accept that makes fill_count==NSYM.
  - FULL: fill_count holds at NSYM; the window keeps sliding.
  - FULL -> FILL only on clear.
- Output timing:
  - full = (state==FULL).
  - dout = full && is_pal(window), driven combinationally from registers. dout is valid the cycle after the accepting edge (latency 1) and holds while din_valid=0.
  - dout_valid is registered: it is 1 for exactly one cycle after each accepting edge and 0 otherwise.
- clear:
  - Next edge: window=0, fill_count=0, state=FILL, dout_valid=0. hit_count is not affected.
  - clear together with din_valid in the same cycle: clear wins and the symbol is dropped.
- Boundary cases:
  - A zero window before full must not assert dout.
  - Back-to-back din_valid is supported at full rate, with no bubbles.
  - Reset asserted mid-stream: all state returns to reset values immediately and asynchronously.

Optional Feature:
PAL_HIT_CNT_EN
- Defined: the hit_count port exists. It increments by 1 on each edge where dout_valid && dout, and saturates at 2^CNT_W-1. It is cleared only by reset.
- Undefined: no hit_count port and no counter logic.

Decomposition:
- Package pal_pkg holds:
  - typedef enum logic {FILL, FULL} pal_state_e
  - the symbol-width legality constants/check
  - function is_palindrome, parametrised through module-level generate
- One natural sub-module: palindrome_check. It is the combinational generalisation of the original detector: WIDTH/SYM_W inputs, 1-bit match output. It is instantiated once on the window register.

Test Plan:
- WIDTH=8, SYM_W=1. Reset, then stream bits 1,0,0,1,1,0,0,1 on consecutive cycles -> dout=0/full=0 for accepts 1..7. After the 8th accept: full=1, dout=1, dout_valid pulse, fill_count=8.
- Continue with bit 0 -> window 8'b0011_0010, dout=0. Idle 5 cycles -> dout and full hold, dout_valid=0.
- WIDTH=16, SYM_W=4. Nibbles A,B,B,A -> window 16'hABBA, dout=1 (symbol-wise palindrome even though the bitwise reverse differs). Then nibble C -> 16'hBBAC, dout=0.
- WIDTH=8. Accept 3 bits, then assert clear with din_valid=1 -> symbol dropped, fill_count=0, full=0. Eight zeros afterwards -> dout=1 only after the 8th.
- Assert reset mid-stream between edges -> all outputs go to 0 immediately. The stream restarts in FILL.
- With PAL_HIT_CNT_EN, CNT_W=2, WIDTH=8: stream all-ones for 6 accepts after full -> hit_count saturates at 3. Clear leaves hit_count=3.
